// File: rtl/mips_defines.sv
// Shared constants for the MIPS pipeline front end.
package mips_defines;
  localparam int unsigned PC_W         = 32;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        CHIP_DISABLE = 1'b0;
endpackage

// File: rtl/if_id.sv
// IF/ID pipeline register between fetch and decode.
module if_id #(
  parameter int unsigned PC_W = mips_defines::PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic [PC_W-1:0] pc,
  input  logic [31:0]     inst,
  input  logic            valid,
  output logic [PC_W-1:0] id_pc,
  output logic [31:0]     id_inst,
  output logic            id_valid
);
  import mips_defines::*;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id_pc    <= ZERO_WORD[PC_W-1:0];
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (!stall) begin
      id_pc    <= pc;
      id_inst  <= inst;
      id_valid <= valid;
    end
  end
endmodule

// File: rtl/pc_reg.sv
// Program counter and ROM chip-enable generation.
module pc_reg #(
  parameter int unsigned          PC_W     = mips_defines::PC_W,
  parameter logic [PC_W-1:0]      RESET_PC = mips_defines::RESET_PC[PC_W-1:0]
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_flag,
  input  logic [PC_W-1:0] branch_target,
  input  logic            flush,
  input  logic [PC_W-1:0] new_pc,
  output logic            ce,
  output logic [PC_W-1:0] pc
);
  import mips_defines::*;

  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  always_ff @(posedge clk) begin
    if (rst) ce <= CHIP_DISABLE;
    else     ce <= CHIP_ENABLE;
  end

  // Redirect addresses are word-aligned by masking the low two bits.
  always_ff @(posedge clk) begin
    if (rst || (ce == CHIP_DISABLE)) pc <= RESET_PC;
    else if (flush)                  pc <= new_pc & ALIGN_MASK;
    else if (stall)                  pc <= pc;
    else if (branch_flag)            pc <= branch_target & ALIGN_MASK;
    else                             pc <= pc + PC_STEP;
  end
endmodule

// File: rtl/if_unit.sv
// Instruction-fetch stage: PC generation, ROM interface and IF/ID register.
module if_unit #(
  parameter int unsigned     PC_W     = mips_defines::PC_W,
  parameter int unsigned     ROM_AW   = 6,
  parameter logic [PC_W-1:0] RESET_PC = mips_defines::RESET_PC[PC_W-1:0]
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_flag,
  input  logic [PC_W-1:0]   branch_target,
  input  logic              flush,
  input  logic [PC_W-1:0]   new_pc,
  input  logic [31:0]       inst_i,
  output logic              ce_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [PC_W-1:0]   id_pc_o,
  output logic [31:0]       id_inst_o,
  output logic              id_valid_o
);
  import mips_defines::*;

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .new_pc        (new_pc),
    .ce            (ce_o),
    .pc            (pc_o)
  );

  // Upper PC bits are not decoded, so the ROM image aliases.
  assign rom_addr_o = pc_o[ROM_AW+1:2];

  if_id #(
    .PC_W (PC_W)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .pc       (pc_o),
    .inst     (inst_i),
    .valid    (ce_o),
    .id_pc    (id_pc_o),
    .id_inst  (id_inst_o),
    .id_valid (id_valid_o)
  );
endmodule

// File: doc/if_unit.md
# if_unit

Instruction-fetch front end for the MIPS pipeline. It generates the program counter, drives the chip-enable and word address of the instruction ROM, and registers the returned instruction with its PC into the IF/ID pipeline register for the decode stage. It handles decode-stage stall, branch/jump redirect, and a pipeline flush to a new PC for exception entry or return.

## Interface
- `PC_W`, 32, PC and instruction width.
- `ROM_AW`, 6, ROM word-address width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `clk` in 1, single clock; all state changes on its rising edge.
- `rst` in 1, synchronous, active-high reset.
- `stall` in 1, decode-stage hold request; 1 freezes the PC and IF/ID.
- `branch_flag` in 1, redirect request from decode.
- `branch_target` in PC_W, redirect address.
- `flush` in 1, pipeline flush from control, used for exception entry or return.
- `new_pc` in PC_W, address used on flush.
- `inst_i` in 32, instruction returned combinationally by the ROM.
- `ce_o` out 1, ROM chip enable.
- `rom_addr_o` out ROM_AW, ROM word address, equal to `pc_o[ROM_AW+1:2]`.
- `pc_o` out PC_W, current fetch PC.
- `id_pc_o` out PC_W, PC of the instruction held in IF/ID.
- `id_inst_o` out 32, instruction held in IF/ID.
- `id_valid_o` out 1, IF/ID holds a real fetched instruction.

## Operation
- **Reset.** While `rst`=1, the block drives `ce_o`=0, `pc_o`=RESET_PC, `id_pc_o`=0, `id_inst_o`=0 and `id_valid_o`=0.
- **Enable.** On the first edge with `rst`=0, `ce_o` becomes 1 and stays at 1 until the next reset. While `ce_o`=0, the PC holds RESET_PC.
- **PC update.** When `ce_o`=1, the PC updates on each edge in this priority order:
  - `flush`: PC loads `{new_pc[PC_W-1:2],2'b00}`.
  - `stall`: PC holds.
  - `branch_flag`: PC loads `{branch_target[PC_W-1:2],2'b00}`.
  - Otherwise: PC loads PC+4, modulo 2^PC_W, so 32'hFFFF_FFFC advances to 0.
- **IF/ID update.** On each edge, in this priority order:
  - `rst` or `flush`: IF/ID is cleared to 0, 0, 0.
  - `stall`: IF/ID holds.
  - Otherwise: IF/ID captures `pc_o`, `inst_i` and `ce_o` into `id_pc_o`, `id_inst_o` and `id_valid_o`.
- **Delay slot.** `branch_flag` does not squash IF/ID. The instruction fetched in the branch cycle is the MIPS delay slot and passes through to decode.
- **Stall with branch.** When `stall` and `branch_flag` are both high, the branch is ignored. Decode must hold `branch_flag` and `branch_target` asserted until `stall` drops.
- **Flush with anything.** `flush` overrides `stall` and `branch_flag` in the same cycle.
- **ROM aliasing.** PC bits above `ROM_AW+1` are not decoded, so the ROM image aliases every 2^(ROM_AW+2) bytes.
- **Mid-run reset.** Asserting `rst` mid-run returns all state to reset values on that edge. Fetch restarts at RESET_PC, with one cycle of `ce_o`=0 first.

## Timing
- The ROM is combinational. `inst_i` corresponds to `pc_o` within the same cycle.
- Fetch-to-decode latency is one cycle. The instruction at PC X appears on `id_inst_o` in the cycle after `pc_o`=X.
- Redirect latency is one cycle. A redirect asserted in cycle n gives `pc_o` equal to the target in cycle n+1.
- The first valid IF/ID entry appears two edges after `rst` falls:
  - Edge 1: `ce_o` rises to 1.
  - Edge 2: `id_valid_o`=1 with `id_pc_o`=RESET_PC.
- All outputs are registered, except `rom_addr_o`, which is a wire slice of `pc_o`.

## Structure
- **Shared package `mips_defines`:**
  - `PC_W`
  - `ZERO_WORD` (32'h0)
  - `NOP_INST` (32'h0)
  - `RESET_PC`
  - `CHIP_ENABLE` / `CHIP_DISABLE` constants
- **Sub-modules.** Split the block into two:
  - `pc_reg`: PC and `ce_o` generation.
  - `if_id`: the pipeline register.
- **Top level.** `if_unit` instantiates both sub-modules and connects the ROM-facing ports.

## Test plan
- **Reset release.** Hold `rst` for 3 cycles, then release. Required response:
  - `ce_o`=0 and `pc_o`=0 during reset.
  - Then `pc_o` runs 0, 4, 8, and so on.
  - `id_pc_o` lags `pc_o` by one cycle.
  - `id_valid_o` rises on the second edge after release.
- **Stall.** Assert `stall` for 2 cycles at `pc_o`=8. Required response: `pc_o` stays 8 and IF/ID holds the entry for PC 4. When `stall` drops, `pc_o` moves to 12.
- **Branch.** Assert `branch_flag` for one cycle at `pc_o`=16 with `branch_target`=32'h40. Required response: the next `pc_o` is 32'h40, and `id_pc_o`=16 (delay slot kept, valid).
- **Simultaneous events.** Assert `flush` with `new_pc`=32'h20 together with `stall` and `branch_flag`. Required response: the next `pc_o` is 32'h20, and IF/ID clears to 0, 0, 0.
- **Misaligned target and wrap.** Two checks:
  - `branch_target`=32'h43: the next `pc_o` is 32'h40.
  - Force a flush to 32'hFFFF_FFFC: the next `pc_o` is 0, and `rom_addr_o` is 6'h3F then 6'h00.
- **Reset mid-run.** Assert `rst` for 1 cycle at `pc_o`=32'h24. Required response: all outputs reach reset values on that edge, and fetch restarts at 0 after one `ce_o`=0 cycle.
